// File: rtl/bram_pkg.sv
// Shared types and constants for the backup-SRAM arbiter.
package bram_pkg;

    // MCU access sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_WSETUP  = 3'd2,
        ST_WSTROBE = 3'd3,
        ST_WHOLD   = 3'd4,
        ST_DONE    = 3'd5
    } bram_arb_st_t;

    // Default number of extra strobe cycles for MCU accesses
    localparam int BRAM_WS_DEF = 2;

    // Saturating 8-bit increment used by the abort counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bram_ce_sync.sv
// Two-flop level synchronizer bringing the decoded CPU select into clk.
module bram_ce_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous level, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/bram_srm_arb.sv
// Backup SRAM arbiter: CPU window passes straight through with absolute
// priority; MCU save-transfer accesses are sequenced with wait states and
// are abandoned and retried whenever the CPU claims the bus.
module bram_srm_arb
    import bram_pkg::*;
#(
    parameter int WS_CYC = BRAM_WS_DEF,
    parameter int AW     = 19
) (
    input  logic          clk,
    input  logic          map_rst,
    input  logic          cpu_ce,
    input  logic          cpu_oe,
    input  logic          cpu_we_lo,
    input  logic          cpu_we_hi,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_di,
    input  logic          mcu_req,
    input  logic          mcu_we,
    input  logic [1:0]    mcu_be,
    input  logic [AW-1:0] mcu_addr,
    input  logic [15:0]   mcu_di,
    output logic [15:0]   mcu_do,
    output logic          mcu_ack,
    output logic          mem_ce,
    output logic          mem_oe,
    output logic          mem_we_lo,
    output logic          mem_we_hi,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_di,
    input  logic [15:0]   mem_do,
    output logic          busy,
    output logic [7:0]    abort_cnt
);

    localparam logic [7:0] WS_LAST = 8'(WS_CYC);

    logic          ce_s;
    bram_arb_st_t  state_r, nxt_state_s;
    logic [7:0]    cnt_r, nxt_cnt_s;
    logic [1:0]    be_r, nxt_be_s;
    logic [AW-1:0] drv_addr_r, nxt_addr_s;
    logic [15:0]   drv_di_r, nxt_di_s;
    logic          drv_ce_r, drv_oe_r, drv_wlo_r, drv_whi_r;
    logic          nxt_ce_s, nxt_oe_s, nxt_wlo_s, nxt_whi_s;
    logic [15:0]   mcu_do_r, nxt_do_s;
    logic          mcu_ack_r, nxt_ack_s;
    logic          busy_r;
    logic [7:0]    abort_cnt_r, nxt_abort_s;
    logic          abort_s;

    bram_ce_sync u_ce_sync (
        .clk (clk),
        .rst (map_rst),
        .d   (cpu_ce),
        .q   (ce_s)
    );

    // State, operand latches, registered MCU drive and status outputs
    always_ff @(posedge clk) begin
        if (map_rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            be_r        <= 2'b00;
            drv_addr_r  <= '0;
            drv_di_r    <= 16'h0000;
            drv_ce_r    <= 1'b0;
            drv_oe_r    <= 1'b0;
            drv_wlo_r   <= 1'b0;
            drv_whi_r   <= 1'b0;
            mcu_do_r    <= 16'h0000;
            mcu_ack_r   <= 1'b0;
            busy_r      <= 1'b0;
            abort_cnt_r <= 8'd0;
        end else begin
            state_r     <= nxt_state_s;
            cnt_r       <= nxt_cnt_s;
            be_r        <= nxt_be_s;
            drv_addr_r  <= nxt_addr_s;
            drv_di_r    <= nxt_di_s;
            drv_ce_r    <= nxt_ce_s;
            drv_oe_r    <= nxt_oe_s;
            drv_wlo_r   <= nxt_wlo_s;
            drv_whi_r   <= nxt_whi_s;
            mcu_do_r    <= nxt_do_s;
            mcu_ack_r   <= nxt_ack_s;
            busy_r      <= (nxt_state_s != ST_IDLE);
            abort_cnt_r <= nxt_abort_s;
        end
    end

    // Next state plus the strobe levels for the cycle being entered
    always_comb begin
        nxt_state_s = state_r;
        nxt_cnt_s   = cnt_r;
        nxt_be_s    = be_r;
        nxt_addr_s  = drv_addr_r;
        nxt_di_s    = drv_di_r;
        nxt_ce_s    = 1'b0;
        nxt_oe_s    = 1'b0;
        nxt_wlo_s   = 1'b0;
        nxt_whi_s   = 1'b0;
        nxt_do_s    = mcu_do_r;
        nxt_ack_s   = 1'b0;
        nxt_abort_s = abort_cnt_r;
        abort_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mcu_req && !ce_s) begin
                    nxt_addr_s = mcu_addr;
                    nxt_di_s   = mcu_di;
                    nxt_be_s   = mcu_be;
                    nxt_cnt_s  = 8'd0;
                    nxt_ce_s   = 1'b1;
                    if (mcu_we) begin
                        nxt_state_s = ST_WSETUP;
                    end else begin
                        nxt_state_s = ST_RD;
                        nxt_oe_s    = 1'b1;
                    end
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (ce_s) begin
                    abort_s = 1'b1;
                end else if (cnt_r == WS_LAST) begin
                    nxt_do_s    = mem_do;
                    nxt_state_s = ST_DONE;
                end else begin
                    nxt_cnt_s = cnt_r + 8'd1;
                    nxt_ce_s  = 1'b1;
                    nxt_oe_s  = 1'b1;
                end
            end
            ST_WSETUP: begin
                if (ce_s) begin
                    abort_s = 1'b1;
                end else begin
                    nxt_state_s = ST_WSTROBE;
                    nxt_cnt_s   = 8'd0;
                    nxt_ce_s    = 1'b1;
                    nxt_wlo_s   = be_r[0];
                    nxt_whi_s   = be_r[1];
                end
            end
            ST_WSTROBE: begin
                if (ce_s) begin
                    abort_s = 1'b1;
                end else if (cnt_r == WS_LAST) begin
                    nxt_state_s = ST_WHOLD;
                    nxt_ce_s    = 1'b1;
                end else begin
                    nxt_cnt_s = cnt_r + 8'd1;
                    nxt_ce_s  = 1'b1;
                    nxt_wlo_s = be_r[0];
                    nxt_whi_s = be_r[1];
                end
            end
            ST_WHOLD: begin
                if (ce_s) begin
                    abort_s = 1'b1;
                end else begin
                    nxt_state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                nxt_ack_s   = 1'b1;
                nxt_state_s = ST_IDLE;
            end
            default: begin
                nxt_state_s = ST_IDLE;
            end
        endcase
        // A CPU claim drops the in-flight access; IDLE re-samples mcu_req
        if (abort_s) begin
            nxt_state_s = ST_IDLE;
            nxt_abort_s = sat_inc8(abort_cnt_r);
        end else begin
            nxt_abort_s = abort_cnt_r;
        end
    end

    // Memory pin mux on the raw select so the CPU wins with zero latency
    always_comb begin
        if (cpu_ce) begin
            mem_ce    = 1'b1;
            mem_oe    = cpu_oe;
            mem_we_lo = cpu_we_lo;
            mem_we_hi = cpu_we_hi;
            mem_addr  = cpu_addr;
            mem_di    = cpu_di;
        end else begin
            mem_ce    = drv_ce_r;
            mem_oe    = drv_oe_r;
            mem_we_lo = drv_wlo_r;
            mem_we_hi = drv_whi_r;
            mem_addr  = drv_addr_r;
            mem_di    = drv_di_r;
        end
    end

    assign mcu_do    = mcu_do_r;
    assign mcu_ack   = mcu_ack_r;
    assign busy      = busy_r;
    assign abort_cnt = abort_cnt_r;

endmodule

// File: tb/tb_bram_srm_arb.sv
// Self-checking bench for bram_srm_arb: CPU mux vector table, directed MCU
// sequences, and random MCU traffic checked against a shadow memory.
module tb_bram_srm_arb;

    localparam int WS = 2;

    logic        clk;
    logic        map_rst;
    logic        cpu_ce, cpu_oe, cpu_we_lo, cpu_we_hi;
    logic [18:0] cpu_addr;
    logic [15:0] cpu_di;
    logic        mcu_req, mcu_we;
    logic [1:0]  mcu_be;
    logic [18:0] mcu_addr;
    logic [15:0] mcu_di;
    logic [15:0] mcu_do;
    logic        mcu_ack;
    logic        mem_ce, mem_oe, mem_we_lo, mem_we_hi;
    logic [18:0] mem_addr;
    logic [15:0] mem_di;
    logic [15:0] mem_do = 16'h0000;
    logic        busy;
    logic [7:0]  abort_cnt;

    int checks = 0;
    int errors = 0;

    logic [15:0] phys   [logic [18:0]];
    logic [15:0] shadow [logic [18:0]];
    logic [15:0] wcur;
    logic        busy_h [0:63];
    logic        yield_we;
    logic [18:0] yield_addr;

    bram_srm_arb #(.WS_CYC(WS), .AW(19)) dut (
        .clk(clk), .map_rst(map_rst),
        .cpu_ce(cpu_ce), .cpu_oe(cpu_oe), .cpu_we_lo(cpu_we_lo), .cpu_we_hi(cpu_we_hi),
        .cpu_addr(cpu_addr), .cpu_di(cpu_di),
        .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_be(mcu_be), .mcu_addr(mcu_addr),
        .mcu_di(mcu_di), .mcu_do(mcu_do), .mcu_ack(mcu_ack),
        .mem_ce(mem_ce), .mem_oe(mem_oe), .mem_we_lo(mem_we_lo), .mem_we_hi(mem_we_hi),
        .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do),
        .busy(busy), .abort_cnt(abort_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input logic [18:0] a);
        return a[15:0] ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] phys_rd(input logic [18:0] a);
        if (phys.exists(a)) return phys[a];
        return init_val(a);
    endfunction

    function automatic logic [15:0] sh_rd(input logic [18:0] a);
        if (shadow.exists(a)) return shadow[a];
        return init_val(a);
    endfunction

    // SRAM model: apply this cycle's write strobes, then present read data
    always @(posedge clk) begin
        #2;
        if (mem_ce && (mem_we_lo || mem_we_hi)) begin
            wcur = phys_rd(mem_addr);
            if (mem_we_lo) wcur[7:0]  = mem_di[7:0];
            if (mem_we_hi) wcur[15:8] = mem_di[15:8];
            phys[mem_addr] = wcur;
        end
        mem_do = phys_rd(mem_addr);
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [18:0] a, input logic [15:0] v);
        phys[a]   = v;
        shadow[a] = v;
    endtask

    // One MCU transaction; optional CPU claim raised after tick pre_tick
    task automatic run_mcu(input logic we, input logic [1:0] be, input logic [18:0] a,
                           input logic [15:0] d, input int pre_tick, input int pre_len,
                           output int lat, output int oe_c, output int wlo_c,
                           output int whi_c, output int acks, output logic [15:0] rd);
        lat = -1; oe_c = 0; wlo_c = 0; whi_c = 0; acks = 0; rd = 16'h0000;
        mcu_we = we; mcu_be = be; mcu_addr = a; mcu_di = d; mcu_req = 1'b1;
        for (int t = 1; t <= 300; t++) begin
            tick();
            if (t < 64) busy_h[t] = busy;
            if (!cpu_ce) begin
                oe_c  += int'(mem_oe);
                wlo_c += int'(mem_we_lo);
                whi_c += int'(mem_we_hi);
            end
            if (mcu_ack) begin
                acks++;
                if (lat < 0) begin
                    lat = t - 1;
                    rd  = mcu_do;
                end
                mcu_req = 1'b0;
            end
            if (t == pre_tick) begin
                cpu_ce = 1'b1; cpu_oe = 1'b1; cpu_we_lo = 1'b0; cpu_we_hi = 1'b0;
                cpu_addr = 19'h2AAAA;
                #1;
                yield_we   = mem_we_lo;
                yield_addr = mem_addr;
            end
            if (t == pre_tick + pre_len) begin
                cpu_ce = 1'b0; cpu_oe = 1'b0;
            end
            if (lat >= 0 && t >= lat + 4) break;
        end
        cpu_ce = 1'b0; cpu_oe = 1'b0; mcu_req = 1'b0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL mcu_timeout actual=no_ack required=ack addr=%0h", a);
        end
    endtask

    typedef struct {
        logic        ce, oe, wlo, whi;
        logic [18:0] addr;
        logic [15:0] di;
        logic        e_ce, e_oe, e_wlo, e_whi;
        logic [18:0] e_addr;
        logic [15:0] e_di;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int lat, oe_c, wlo_c, whi_c, acks, nack;
        logic [15:0] rd;
        logic [31:0] oe_mask, ack_mask;
        logic we_r;
        logic [1:0] be_r;
        logic [18:0] a_r;
        logic [15:0] d_r;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 19'h12345, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 19'h12345, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 19'h7FFFF, 16'hA5A5, 1'b1, 1'b0, 1'b1, 1'b0, 19'h7FFFF, 16'hA5A5};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 19'h00001, 16'h5A5A, 1'b1, 1'b0, 1'b0, 1'b1, 19'h00001, 16'h5A5A};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 19'h40000, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 19'h40000, 16'hFFFF};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 19'h00003, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 19'h00000, 16'h0000};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 19'h55555, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b0, 19'h00000, 16'h0000};

        // Reset with random inputs, CPU deselected
        map_rst = 1'b1; cpu_ce = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cpu_oe = 1'($urandom); cpu_we_lo = 1'($urandom); cpu_we_hi = 1'($urandom);
            cpu_addr = 19'($urandom); cpu_di = 16'($urandom);
            mcu_req = 1'($urandom); mcu_we = 1'($urandom); mcu_be = 2'($urandom);
            mcu_addr = 19'($urandom); mcu_di = 16'($urandom);
            tick();
        end
        chk("rst_mcu_do", mcu_do, 16'h0000);
        chk("rst_ack", mcu_ack, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_abort", abort_cnt, 8'd0);
        chk("rst_strobes", {mem_ce, mem_oe, mem_we_lo, mem_we_hi}, 4'b0000);
        chk("rst_addr", mem_addr, 19'h00000);
        chk("rst_di", mem_di, 16'h0000);
        map_rst = 1'b0;
        cpu_oe = 1'b0; cpu_we_lo = 1'b0; cpu_we_hi = 1'b0; cpu_addr = 19'h0; cpu_di = 16'h0;
        mcu_req = 1'b0; mcu_we = 1'b0; mcu_be = 2'b00; mcu_addr = 19'h0; mcu_di = 16'h0;
        tick();

        // CPU pass-through mux vectors, FSM idle
        for (int i = 0; i < 6; i++) begin
            cpu_ce = vecs[i].ce; cpu_oe = vecs[i].oe; cpu_we_lo = vecs[i].wlo;
            cpu_we_hi = vecs[i].whi; cpu_addr = vecs[i].addr; cpu_di = vecs[i].di;
            #1;
            chk($sformatf("vec%0d_ce", i), mem_ce, vecs[i].e_ce);
            chk($sformatf("vec%0d_oe", i), mem_oe, vecs[i].e_oe);
            chk($sformatf("vec%0d_wlo", i), mem_we_lo, vecs[i].e_wlo);
            chk($sformatf("vec%0d_whi", i), mem_we_hi, vecs[i].e_whi);
            chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_di", i), mem_di, vecs[i].e_di);
            tick();
        end
        cpu_ce = 1'b0; cpu_oe = 1'b0; cpu_we_lo = 1'b0; cpu_we_hi = 1'b0;
        repeat (3) tick();

        // MCU read
        preload(19'h00123, 16'hBEEF);
        run_mcu(1'b0, 2'b00, 19'h00123, 16'h0000, 0, 0, lat, oe_c, wlo_c, whi_c, acks, rd);
        chk("rd_latency", lat, WS + 2);
        chk("rd_oe_cycles", oe_c, WS + 1);
        chk("rd_data", rd, 16'hBEEF);
        chk("rd_acks", acks, 1);

        // MCU write, low byte only
        preload(19'h7FFFF, 16'h1234);
        run_mcu(1'b1, 2'b01, 19'h7FFFF, 16'h55AA, 0, 0, lat, oe_c, wlo_c, whi_c, acks, rd);
        chk("wr_latency", lat, WS + 4);
        chk("wr_wlo_cycles", wlo_c, WS + 1);
        chk("wr_whi_cycles", whi_c, 0);
        chk("wr_acks", acks, 1);
        chk("wr_mem", phys_rd(19'h7FFFF), 16'h12AA);

        // Random clean traffic against the shadow memory
        for (int i = 0; i < 40; i++) begin
            we_r = 1'($urandom); be_r = 2'($urandom_range(1, 3));
            a_r = 19'h10000 + 19'($urandom_range(0, 15)); d_r = 16'($urandom);
            run_mcu(we_r, be_r, a_r, d_r, 0, 0, lat, oe_c, wlo_c, whi_c, acks, rd);
            chk("rand_latency", lat, we_r ? WS + 4 : WS + 2);
            chk("rand_acks", acks, 1);
            if (we_r) begin
                wcur = sh_rd(a_r);
                if (be_r[0]) wcur[7:0]  = d_r[7:0];
                if (be_r[1]) wcur[15:8] = d_r[15:8];
                shadow[a_r] = wcur;
            end else begin
                chk("rand_rdata", rd, sh_rd(a_r));
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        for (int k = 0; k < 16; k++) begin
            a_r = 19'h10000 + 19'(k);
            chk("rand_final_mem", phys_rd(a_r), sh_rd(a_r));
        end

        // CPU pre-emption during the second WSTROBE cycle
        preload(19'h00100, 16'hC3C3);
        run_mcu(1'b1, 2'b01, 19'h00100, 16'h7711, 3, 6, lat, oe_c, wlo_c, whi_c, acks, rd);
        chk("pre_yield_we", yield_we, 1'b0);
        chk("pre_yield_addr", yield_addr, 19'h2AAAA);
        chk("pre_busy_t5", busy_h[5], 1'b1);
        chk("pre_idle_t6", busy_h[6], 1'b0);
        chk("pre_wait_t11", busy_h[11], 1'b0);
        chk("pre_retry_t12", busy_h[12], 1'b1);
        chk("pre_abort_cnt", abort_cnt, 8'd1);
        chk("pre_latency", lat, 17);
        chk("pre_acks", acks, 1);
        chk("pre_whi", whi_c, 0);
        chk("pre_mem", phys_rd(19'h00100), 16'hC311);

        // Back-to-back reads with mcu_req held over two acks
        oe_mask = 32'h0; ack_mask = 32'h0; nack = 0;
        mcu_we = 1'b0; mcu_addr = 19'h10003; mcu_req = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (mem_oe) oe_mask[t] = 1'b1;
            if (mcu_ack) begin
                ack_mask[t] = 1'b1;
                nack++;
                if (nack == 2) mcu_req = 1'b0;
            end
        end
        mcu_req = 1'b0;
        chk("b2b_oe_mask", oe_mask, 32'h0000_01CE);
        chk("b2b_ack_mask", ack_mask, 32'h0000_0420);
        chk("b2b_rdata", mcu_do, sh_rd(19'h10003));

        // Abort counter saturation
        mcu_we = 1'b0; mcu_addr = 19'h10000; mcu_req = 1'b1;
        for (int i = 0; i < 300; i++) begin
            for (int w = 0; w <= 20; w++) begin
                if (busy) break;
                if (w == 20) begin checks++; errors++; $display("FAIL sat_wait_busy actual=0 required=1"); end
                tick();
            end
            cpu_ce = 1'b1;
            tick();
            cpu_ce = 1'b0;
            for (int w = 0; w <= 20; w++) begin
                if (!busy) break;
                if (w == 20) begin checks++; errors++; $display("FAIL sat_wait_idle actual=1 required=0"); end
                tick();
            end
            if (i == 99) chk("sat_abort_101", abort_cnt, 8'd101);
        end
        mcu_req = 1'b0;
        repeat (4) tick();
        chk("sat_abort_255", abort_cnt, 8'd255);

        // Random MCU reads with random CPU claims: each request acks once
        for (int i = 0; i < 20; i++) begin
            a_r = 19'($urandom);
            run_mcu(1'b0, 2'b00, a_r, 16'h0000, $urandom_range(1, 6), $urandom_range(1, 4),
                    lat, oe_c, wlo_c, whi_c, acks, rd);
            chk("intf_acks", acks, 1);
            chk("intf_lat_min", lat >= WS + 2, 1'b1);
            repeat (3) tick();
        end
        chk("intf_abort_sat", abort_cnt, 8'd255);

        // Reset mid-write: strobes drop, no ack follows
        mcu_we = 1'b1; mcu_be = 2'b11; mcu_addr = 19'h00200; mcu_di = 16'h1111; mcu_req = 1'b1;
        repeat (3) tick();
        chk("mrst_busy_before", busy, 1'b1);
        map_rst = 1'b1; mcu_req = 1'b0;
        tick();
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_strobes", {mem_ce, mem_oe, mem_we_lo, mem_we_hi}, 4'b0000);
        chk("mrst_abort", abort_cnt, 8'd0);
        map_rst = 1'b0;
        acks = 0;
        for (int t = 0; t < 8; t++) begin
            if (mcu_ack) acks++;
            tick();
        end
        chk("mrst_no_ack", acks, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_srm_arb.md
# bram_srm_arb

Shares the cartridge backup SRAM between the Mega Drive CPU window and the MCU save-transfer port, which dumps and restores battery RAM to and from SD. It sits between the SMD SRAM decoder and the physical memory pins. The CPU path is a zero-latency pass-through with absolute priority. MCU accesses are sequenced by an FSM with programmable wait states and are aborted and retried whenever the CPU claims the bus.

## Interface
Parameters:
- WS_CYC, 2: extra cycles the strobe is held for MCU accesses (strobe width = WS_CYC+1).
- AW, 19: memory word/byte address width.

Ports:
- clk  in  1  system clock; the only clock.
- map_rst  in  1  reset, synchronous, active-high.
- cpu_ce  in  1  decoded SRAM select from the SMD decoder; asynchronous to clk.
- cpu_oe, cpu_we_lo, cpu_we_hi  in  1  CPU strobes, active-high, already qualified by cpu_ce.
- cpu_addr  in  AW  CPU address.
- cpu_di  in  16  CPU write data.
- mcu_req  in  1  MCU access request, level.
- mcu_we  in  1  1 = write, 0 = read.
- mcu_be  in  2  byte enables {hi,lo} for writes.
- mcu_addr  in  AW  MCU address.
- mcu_di  in  16  MCU write data.
- mcu_do  out  16  read data, valid with mcu_ack.
- mcu_ack  out  1  one-cycle completion pulse.
- mem_ce, mem_oe, mem_we_lo, mem_we_hi  out  1  SRAM strobes.
- mem_addr  out  AW  SRAM address.
- mem_di  out  16  SRAM write data.
- mem_do  in  16  SRAM read data.
- busy  out  1  FSM not in IDLE.
- abort_cnt  out  8  saturating count of MCU aborts, for debug.

## Operation
- Output mux, combinational on raw cpu_ce:
  - cpu_ce=1: all mem_* outputs follow the cpu_* inputs.
  - cpu_ce=0: mem_* outputs follow the FSM's registered MCU drive.
- cpu_ce is also passed through a 2-flop synchronizer to produce ce_s. The FSM uses only ce_s.
- FSM states: IDLE, RD, WSETUP, WSTROBE, WHOLD, DONE.
  - IDLE: if mcu_req & !ce_s, go to RD (mcu_we=0) or WSETUP (mcu_we=1). The address, data and byte enables are latched in the same cycle.
  - RD: ce=oe=1 for WS_CYC+1 cycles (counter). Then latch mem_do into mcu_do and go to DONE.
  - WSETUP: ce=1, we=0, 1 cycle, then WSTROBE.
  - WSTROBE: ce=1, we_lo/we_hi per the latched byte enables, for WS_CYC+1 cycles, then WHOLD.
  - WHOLD: ce=1, we=0, 1 cycle, then DONE.
  - DONE: mcu_ack=1 for exactly one cycle, then IDLE.
- Abort: ce_s=1 in RD, WSETUP, WSTROBE or WHOLD sends the FSM to IDLE without an ack. abort_cnt increments, saturating at 255. The latched request is discarded and re-sampled from mcu_req, so the retry is transparent to the MCU.
  - The MCU-side we is already deasserted the moment raw cpu_ce rises, via the mux.
- Handshake: the MCU holds mcu_req and its operands stable until mcu_ack. mcu_req is re-sampled in the IDLE cycle after DONE. If it is still high, a new access starts.
- The FSM-driven mem_addr and mem_di hold their last values in IDLE. The strobes are 0 in IDLE.

## Timing
- Reset values:
  - FSM: IDLE.
  - mcu_ack=0, mcu_do=0, busy=0, abort_cnt=0.
  - FSM drive: addr=0, di=0, strobes 0.
  - With cpu_ce=0, all mem_* outputs are 0.
- map_rst asserted mid-access forces IDLE on the next edge with strobes low. No ack is issued.
- CPU path latency: 0 cycles, purely combinational.
- MCU read latency, from the req-sample edge to mcu_ack: WS_CYC+2 cycles. Default: 4.
- MCU write latency: WS_CYC+4 cycles. Default: 6.
- Abort reaction: strobes yield instantly via the mux. The FSM reaches IDLE 3 cycles after cpu_ce rises (2 synchronizer cycles + 1).
- A request that coincides with ce_s=1 in IDLE waits; no access starts.

## Structure
- Shared package bram_pkg holds:
  - the state enum type bram_arb_st_t;
  - the constant BRAM_WS_DEF = 2.
- Sub-module: bram_ce_sync, a 2-flop level synchronizer with synchronous active-high reset to 0.
- Everything else lives in one module: FSM, wait-state counter, operand latches, output mux.

## Test plan
- Reset: map_rst for 2 cycles with random inputs, cpu_ce=0 → all outputs 0, busy=0.
- MCU read: mcu_req=1, addr=0x00123, mem model holds 0xBEEF → oe high for 3 cycles, mcu_do=0xBEEF with a one-cycle ack exactly 4 cycles after the sample edge.
- MCU write: be=2'b01, data=0x55AA, addr=0x7FFFF → mem_we_lo high for 3 cycles, mem_we_hi never high, ack at cycle 6, model low byte = 0xAA, high byte unchanged.
- CPU pre-emption: raise cpu_ce during cycle 2 of WSTROBE → mem_we_lo follows cpu_we_lo in the same cycle, FSM in IDLE 3 cycles later, abort_cnt=1, retried write completes after cpu_ce falls, exactly one ack.
- Back-to-back: hold mcu_req high over two ack pulses → second access begins in the cycle after the first DONE, with no strobe overlap.
- Saturation: force 300 aborts → abort_cnt holds at 255.
